avg_accum: RTL

- Parametrised streaming block-averager: accepts samples over a valid/ready handshake and accumulates 2^LOG2_N of them.
- Emits their mean, truncated or rounded, on a registered valid/ready output.
- Next-generation averager stage feeding the RAM write path.
- Replaces externally sequenced enable/zero/output strobes with an internal sample counter and handshakes.

---
 rtl/avg_pkg.sv | 25 ++
 rtl/avg_accum.sv | 105 ++++++++++
 2 files changed

// File: rtl/avg_pkg.sv
// avg_pkg: shared types and helpers for the streaming block averager.
//   avg_state_e     - window fill state (empty / filling / last sample pending)
//   avg_round_shift - divide an accumulated window sum by 2^log2_n,
//                     optionally rounding half-up first
package avg_pkg;

    typedef enum logic [1:0] {
        AVG_EMPTY   = 2'd0,
        AVG_FILLING = 2'd1,
        AVG_LAST    = 2'd2
    } avg_state_e;

    // Operates on a 64-bit container so any legal DATA_W/LOG2_N combination
    // fits; callers cast the result down to their output width.
    function automatic logic [63:0] avg_round_shift(
        input logic [63:0] acc_sum,
        input logic        round_en,
        input int          log2_n
    );
        logic [63:0] rnd;
        rnd = round_en ? (64'd1 << (log2_n - 1)) : 64'd0;
        return (acc_sum + rnd) >> log2_n;
    endfunction

endpackage

// File: rtl/avg_accum.sv
// avg_accum: streaming block averager. Accepts unsigned samples on a
// valid/ready input, sums 2^LOG2_N of them and presents the mean
// (truncated or rounded half-up) on a registered valid/ready output.
//
// Ports:
//   clk_2      in   clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   clr        in   discard the partial window (pending output untouched)
//   in_valid   in   sample present
//   in_data    in   [DATA_W] unsigned sample
//   in_ready   out  sample can be accepted this cycle
//   out_valid  out  average present
//   out_data   out  [DATA_W] average
//   out_ready  in   consumer takes the average
//   sample_cnt out  [LOG2_N] samples accepted in the current window
module avg_accum
    import avg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 2,
    parameter int ROUND  = 1
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [LOG2_N-1:0] sample_cnt
);

    // N*(2^DATA_W-1) always fits in DATA_W+LOG2_N bits; the rounding
    // constant is added inside the 64-bit helper, so no overflow handling.
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

    avg_state_e        state_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [LOG2_N-1:0] cnt_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;

    logic              accept;
    logic              closing;
    logic [ACC_W-1:0]  acc_next;
    logic [LOG2_N-1:0] cnt_next;
    logic [DATA_W-1:0] mean_next;

    // Only the window-closing sample stalls, and only while the previous
    // average is still waiting for the consumer.
    assign in_ready = !(state_reg == AVG_LAST && out_valid_reg && !out_ready);
    assign accept   = in_valid && in_ready;
    assign closing  = accept && !clr && (state_reg == AVG_LAST);

    assign acc_next  = acc_reg + ACC_W'(in_data);
    assign cnt_next  = cnt_reg + CNT_ONE;
    assign mean_next = DATA_W'(avg_round_shift(64'(acc_next), ROUND != 0, LOG2_N));

    // Window FSM, counter and accumulator. acc only ever loads in_data on an
    // accepted sample, so undriven data while in_valid is low never enters.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= AVG_EMPTY;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (clr) begin
            state_reg <= AVG_EMPTY;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (accept) begin
            if (state_reg == AVG_LAST) begin
                state_reg <= AVG_EMPTY;
                acc_reg   <= '0;
                cnt_reg   <= '0;
            end else begin
                state_reg <= (cnt_next == CNT_LAST) ? AVG_LAST : AVG_FILLING;
                acc_reg   <= acc_next;
                cnt_reg   <= cnt_next;
            end
        end
    end

    // Output register: a closing window overrides the consumer handshake so
    // back-to-back averages go out without a bubble.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (closing) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= mean_next;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign sample_cnt = cnt_reg;

endmodule
